dmem_arbiter: RTL

- Two-port round-robin arbiter and access sequencer in front of the single shared data_memory.
- Requester 0 is the CPU load/store stage; requester 1 is the debug/loader port.
- Serialises word accesses through a 3-state FSM and drives the memory's address/writeData/memWrite/memRead strobes.
- Returns read data or an error to the granted requester with a one-cycle done pulse.

---
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter and access sequencer in front of the single shared
//   data memory. Requester 0 is the CPU load/store stage, requester 1 is the
//   debug/loader port. One word access is serialised per IDLE->ACCESS->DONE
//   pass, so accesses can complete back to back every 3 cycles.
//
// Handshake: a requester raises mN_req with mN_we/mN_addr/mN_wdata stable and
//   holds req until it sees a one-cycle mN_done. req is only sampled in IDLE;
//   once granted, dropping req does not abort the access. mN_err and
//   mN_rdata are valid in the cycle where mN_done is high, and mN_rdata keeps
//   its value until that requester's next successful read.
//
// Ports:
//   clock, reset      system clock (rising edge), async active-low reset
//   m0_* / m1_*       requester request/response ports
//   mem_*             address, write data and strobes to data_memory;
//                     mem_readData is data_memory's combinational read port
//   dbg_state         current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
module dmem_arbiter #(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int memory_size   = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [address_width-1:0] m0_addr,
  input  logic [data_width-1:0]    m0_wdata,
  output logic                     m0_done,
  output logic                     m0_err,
  output logic [data_width-1:0]    m0_rdata,
  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [address_width-1:0] m1_addr,
  input  logic [data_width-1:0]    m1_wdata,
  output logic                     m1_done,
  output logic                     m1_err,
  output logic [data_width-1:0]    m1_rdata,
  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_writeData,
  output logic                     mem_memWrite,
  output logic                     mem_memRead,
  input  logic [data_width-1:0]    mem_readData,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]    wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic                     err_q, err_d;
  logic                     last_grant_q, last_grant_d;
  logic [data_width-1:0]    rdata0_q, rdata0_d;
  logic [data_width-1:0]    rdata1_q, rdata1_d;

  logic                     grant_valid;
  logic                     grant_id;
  logic [address_width-1:0] sel_addr;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    grant_valid  = 1'b0;
    grant_id     = 1'b0;
    sel_addr     = m0_addr;

    // On a tie the requester that was not served last wins.
    if (m0_req && m1_req) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant_q;
    end else if (m0_req) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (m1_req) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
    sel_addr = grant_id ? m1_addr : m0_addr;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_id;
          addr_d  = sel_addr;
          wdata_d = grant_id ? m1_wdata : m0_wdata;
          we_d    = grant_id ? m1_we : m0_we;
          // Any address bit above the memory index means out of range.
          err_d   = |sel_addr[address_width-1:memory_size];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Errored accesses never read, so the owner's rdata is left intact.
        if (!we_q && !err_q) begin
          if (owner_q) rdata1_d = mem_readData;
          else         rdata0_d = mem_readData;
        end
        state_d = DONE;
      end
      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Outputs decode registered state only, so an asynchronous reset drops
  // the strobes immediately and nothing here is combinational from req.
  assign mem_address   = addr_q;
  assign mem_writeData = wdata_q;
  assign mem_memWrite  = (state_q == ACCESS) && we_q && !err_q;
  assign mem_memRead   = (state_q == ACCESS) && !we_q && !err_q;

  assign m0_done  = (state_q == DONE) && !owner_q;
  assign m1_done  = (state_q == DONE) && owner_q;
  assign m0_err   = m0_done && err_q;
  assign m1_err   = m1_done && err_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

  assign dbg_state = state_q;

endmodule
